// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operator blocks.
package calc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } pow_state_t;

    // Calculator convention: 0**0 evaluates to 0, not 1.
    localparam int unsigned POW_ZERO_POW_ZERO = 0;

endpackage

// File: rtl/pow_mul_chk.sv
// Truncating multiplier that also reports whether the full product exceeded W bits.
module pow_mul_chk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         ovf
);

    logic [2*W-1:0] full;

    always_comb begin
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p    = full[W-1:0];
        ovf  = |full[2*W-1:W];
    end

endmodule

// File: rtl/power_seq.sv
// Sequential square-and-multiply exponentiation, one exponent bit per clock.
//   state | meaning
//   IDLE  | waiting for start; result/overflow hold the last answer
//   CALC  | consuming exponent bits LSB first, done pulses on exit
module power_seq
    import calc_pkg::*;
#(
    parameter int WIDTH_BASE = 4,
    parameter int WIDTH_EXP  = 4,
    parameter int WIDTH_RES  = 8,
    parameter int SAT_MODE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH_BASE-1:0] base,
    input  logic [WIDTH_EXP-1:0]  exp,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH_RES-1:0]  result,
    output logic                  overflow
);

    generate
        if (WIDTH_RES < WIDTH_BASE) begin : g_width_chk
            $error("power_seq: WIDTH_RES must be >= WIDTH_BASE");
        end
    endgenerate

    pow_state_t           state;
    logic [WIDTH_RES-1:0] acc;
    logic [WIDTH_RES-1:0] r;
    logic [WIDTH_EXP-1:0] e;
    logic                 acc_ovf;
    logic                 r_ovf;
    logic                 first;

    logic [WIDTH_RES-1:0] p_r;
    logic [WIDTH_RES-1:0] p_a;
    logic                 ovf_r;
    logic                 ovf_a;

    logic [WIDTH_EXP-1:0] e_nxt;
    logic [WIDTH_RES-1:0] r_nxt;
    logic                 r_ovf_nxt;
    logic                 trivial;
    logic [WIDTH_RES-1:0] triv_res;
    logic [WIDTH_RES-1:0] fin_res;

    pow_mul_chk #(.W(WIDTH_RES)) u_mul_r (
        .a   (r),
        .b   (acc),
        .p   (p_r),
        .ovf (ovf_r)
    );

    pow_mul_chk #(.W(WIDTH_RES)) u_mul_a (
        .a   (acc),
        .b   (acc),
        .p   (p_a),
        .ovf (ovf_a)
    );

    // acc may wrap to 0/1 later in a run, so trivial detection is gated to the first CALC cycle.
    always_comb begin
        e_nxt     = e >> 1;
        r_nxt     = e[0] ? p_r : r;
        r_ovf_nxt = r_ovf | (e[0] & (ovf_r | acc_ovf));
        trivial   = first && ((acc <= WIDTH_RES'(1)) || (e == '0));
        if (acc == '0) begin
            triv_res = (e == '0) ? WIDTH_RES'(POW_ZERO_POW_ZERO) : '0;
        end else begin
            triv_res = WIDTH_RES'(1);
        end
        fin_res   = ((SAT_MODE != 0) && r_ovf_nxt) ? '1 : r_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            r        <= '0;
            e        <= '0;
            acc_ovf  <= 1'b0;
            r_ovf    <= 1'b0;
            first    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc     <= WIDTH_RES'(base);
                        r       <= WIDTH_RES'(1);
                        e       <= exp;
                        acc_ovf <= 1'b0;
                        r_ovf   <= 1'b0;
                        first   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    first <= 1'b0;
                    if (trivial) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= triv_res;
                        overflow <= 1'b0;
                    end else begin
                        acc     <= p_a;
                        acc_ovf <= acc_ovf | ovf_a;
                        r       <= r_nxt;
                        r_ovf   <= r_ovf_nxt;
                        e       <= e_nxt;
                        if (e_nxt == '0) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            result   <= fin_res;
                            overflow <= r_ovf_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_seq.sv
// Bench for power_seq: three instances (8-bit saturating, 8-bit wrapping, 16-bit) in lockstep.
module tb_power_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] base;
    logic [3:0] exp;

    logic        busy_s8, done_s8, ov_s8;
    logic [7:0]  res_s8;
    logic        busy_w8, done_w8, ov_w8;
    logic [7:0]  res_w8;
    logic        busy_s16, done_s16, ov_s16;
    logic [15:0] res_s16;

    power_seq dut_s8 (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
        .busy(busy_s8), .done(done_s8), .result(res_s8), .overflow(ov_s8)
    );

    power_seq #(.SAT_MODE(0)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
        .busy(busy_w8), .done(done_w8), .result(res_w8), .overflow(ov_w8)
    );

    power_seq #(.WIDTH_RES(16)) dut_s16 (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exp(exp),
        .busy(busy_s16), .done(done_s16), .result(res_s16), .overflow(ov_s16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r8s;
        logic [7:0]  r8w;
        logic        ov8;
        logic [15:0] r16;
        logic        ov16;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0] b;
        logic [3:0] x;
        logic [7:0] r8s;
        logic [7:0] r8w;
        logic       ov8;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic exp_t model(input logic [3:0] b, input logic [3:0] x);
        exp_t m;
        longint unsigned p = 1;
        for (int i = 0; i < int'(x); i++) p = p * b;
        if (b == 0) p = 0;
        m.ov8  = (p >= 256);
        m.ov16 = (p >= 65536);
        m.r8w  = p[7:0];
        m.r8s  = m.ov8 ? 8'hFF : p[7:0];
        m.r16  = m.ov16 ? 16'hFFFF : p[15:0];
        if (b <= 1 || x == 0) m.lat = 1;
        else begin
            m.lat = 0;
            for (int i = 0; i < 4; i++) if (x[i]) m.lat = i + 1;
        end
        return m;
    endfunction

    task automatic issue(input logic [3:0] b, input logic [3:0] x, input bit push, input exp_t ex);
        start = 1'b1;
        base  = b;
        exp   = x;
        if (push) sb.push_back(ex);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic collect(input int cyc0);
        int   cyc = cyc0;
        bit   bok = 1'b1;
        exp_t ex;
        while (cyc < 24) begin
            @(posedge clk);
            #1 cyc++;
            if (done_s8) break;
            if (!busy_s8) bok = 1'b0;
        end
        ex = sb.pop_front();
        if (!done_s8) begin
            n_total++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
            return;
        end
        chk("result_sat8", res_s8, ex.r8s);
        chk("ovf_sat8", ov_s8, ex.ov8);
        chk("result_wrap8", res_w8, ex.r8w);
        chk("ovf_wrap8", ov_w8, ex.ov8);
        chk("result_sat16", res_s16, ex.r16);
        chk("ovf_sat16", ov_s16, ex.ov16);
        chk("latency", cyc, ex.lat);
        chk("busy_during_calc", bok, 1);
        chk("busy_at_done", {busy_s8, busy_w8, busy_s16}, 0);
        chk("done_all", {done_w8, done_s16}, 2'b11);
    endtask

    initial begin
        exp_t ex;
        bit   seen;

        vecs[0] = '{b: 2,  x: 7,  r8s: 128, r8w: 128, ov8: 0, lat: 3};
        vecs[1] = '{b: 3,  x: 5,  r8s: 243, r8w: 243, ov8: 0, lat: 3};
        vecs[2] = '{b: 2,  x: 8,  r8s: 255, r8w: 0,   ov8: 1, lat: 4};
        vecs[3] = '{b: 3,  x: 6,  r8s: 255, r8w: 217, ov8: 1, lat: 3};
        vecs[4] = '{b: 15, x: 15, r8s: 255, r8w: 239, ov8: 1, lat: 4};
        vecs[5] = '{b: 0,  x: 0,  r8s: 0,   r8w: 0,   ov8: 0, lat: 1};
        vecs[6] = '{b: 0,  x: 9,  r8s: 0,   r8w: 0,   ov8: 0, lat: 1};
        vecs[7] = '{b: 7,  x: 0,  r8s: 1,   r8w: 1,   ov8: 0, lat: 1};
        vecs[8] = '{b: 1,  x: 15, r8s: 1,   r8w: 1,   ov8: 0, lat: 1};

        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {busy_s8, busy_w8, busy_s16}, 0);
        chk("reset_done", {done_s8, done_w8, done_s16}, 0);
        chk("reset_result", {res_s8, res_w8, res_s16}, 0);
        chk("reset_ovf", {ov_s8, ov_w8, ov_s16}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ex      = model(vecs[i].b, vecs[i].x);
            ex.r8s  = vecs[i].r8s;
            ex.r8w  = vecs[i].r8w;
            ex.ov8  = vecs[i].ov8;
            ex.lat  = vecs[i].lat;
            @(negedge clk);
            issue(vecs[i].b, vecs[i].x, 1'b1, ex);
            collect(0);
        end

        // A start while busy must not disturb the run in flight nor launch a second one.
        @(negedge clk);
        issue(4'd2, 4'd7, 1'b1, model(4'd2, 4'd7));
        @(negedge clk);
        start = 1'b1;
        base  = 4'd3;
        exp   = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        collect(1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (done_s8 || busy_s8) seen = 1'b1;
        end
        chk("ignored_start_no_rerun", seen, 0);

        // Start in the done cycle is accepted.
        @(negedge clk);
        issue(4'd3, 4'd5, 1'b1, model(4'd3, 4'd5));
        collect(0);
        issue(4'd7, 4'd2, 1'b1, model(4'd7, 4'd2));
        collect(0);

        // Reset in the middle of a run.
        @(negedge clk);
        issue(4'd15, 4'd15, 1'b0, ex);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {busy_s8, busy_w8, busy_s16}, 0);
        chk("midrst_done", {done_s8, done_w8, done_s16}, 0);
        chk("midrst_result", {res_s8, res_w8, res_s16}, 0);
        chk("midrst_ovf", {ov_s8, ov_w8, ov_s16}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done_s8 || done_w8 || done_s16) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);

        // Full operand sweep in shuffled order, some issued back-to-back on done.
        for (int k = 0; k < 256; k++) begin
            logic [7:0] idx;
            idx = 8'(k * 37 + 11);
            if ($urandom_range(1, 0) == 0) @(negedge clk);
            issue(idx[7:4], idx[3:0], 1'b1, model(idx[7:4], idx[3:0]));
            collect(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
